// File: rtl/pattern_det_pkg.sv
// Shared types and constants for the programmable pattern detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pattern_det_pkg;

  // Control FSM encoding
  typedef enum logic [1:0] {
    S_UNCFG = 2'b00,
    S_RUN   = 2'b01,
    S_ERR   = 2'b10
  } state_t;

  // Symbol names for the single-bit Bike/Car stream
  localparam logic B = 1'b0;
  localparam logic C = 1'b1;

endpackage

// File: rtl/pattern_det_hist.sv
// Symbol history shift register with per-position equality against an aligned pattern.
// Latency: eq is combinational on d_in and the stored history; history updates one edge after shift_en.
// Backpressure: none; one symbol per clock when shift_en is high.
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   shift_en    : shift d_in into the history
//   flush       : clear the history (takes priority over shift_en)
//   d_in        : incoming symbol
//   pat         : pattern aligned so that pat[i] is expected i symbols before d_in
//   eq          : eq[i] = 1 when the symbol i positions back matches pat[i]
module pattern_det_hist #(
  parameter int SYM_W   = 1,
  parameter int MAX_LEN = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            shift_en,
  input  logic                            flush,
  input  logic [SYM_W-1:0]                d_in,
  input  logic [MAX_LEN-1:0][SYM_W-1:0]   pat,
  output logic [MAX_LEN-1:0]              eq
);

  // Only MAX_LEN-1 older symbols are stored: together with the incoming
  // d_in they make up the full MAX_LEN-symbol window used by the compare.
  logic [MAX_LEN-2:0][SYM_W-1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else if (flush) begin
      hist_q <= '0;
    end else if (shift_en) begin
      hist_q[0] <= d_in;
      for (int i = 1; i < MAX_LEN - 1; i++) begin
        hist_q[i] <= hist_q[i-1];
      end
    end
  end

  // Position 0 is the symbol arriving this cycle; position i>0 is hist_q[i-1].
  always_comb begin
    eq    = '0;
    eq[0] = (d_in == pat[0]);
    for (int i = 1; i < MAX_LEN; i++) begin
      eq[i] = (hist_q[i-1] == pat[i]);
    end
  end

endmodule

// File: rtl/pattern_det_prog.sv
// Runtime-programmable serial pattern detector with overlap select and saturating match counter.
// Latency: pattern_detected pulses the cycle after the edge sampling the completing symbol.
// Backpressure: none; accepts one symbol per clock whenever valid_in is high.
//
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   cfg_load          : pulse capturing cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern       : pattern, symbol 0 (first received) in the low SYM_W bits
//   cfg_len           : pattern length, legal 1..MAX_LEN
//   cfg_overlap       : 1 = overlapping matches, 0 = restart after a match
//   valid_in, d_in    : qualified input symbol stream
//   count_clr         : synchronous clear of match_count
//   armed, cfg_err    : legal config running / last load was illegal
//   pattern_detected  : one-cycle pulse per match
//   match_count       : saturating match counter
module pattern_det_prog #(
  parameter int SYM_W   = 1,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_load,
  input  logic [MAX_LEN*SYM_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic                     cfg_overlap,
  input  logic                     valid_in,
  input  logic [SYM_W-1:0]         d_in,
  input  logic                     count_clr,
  output logic                     armed,
  output logic                     cfg_err,
  output logic                     pattern_detected,
  output logic [CNT_W-1:0]         match_count
);

  import pattern_det_pkg::*;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t                        state_q, state_d;
  logic                          armed_d, cfg_err_d;
  logic [LEN_W-1:0]              len_q;
  logic                          overlap_q;
  logic [MAX_LEN-1:0][SYM_W-1:0] pat_al_q, pat_al_d;
  logic [MAX_LEN-1:0][SYM_W-1:0] cfg_pat_arr;
  logic [LEN_W-1:0]              fill_q, fill_inc;
  logic [MAX_LEN-1:0]            eq, len_mask;
  logic                          cfg_ok, accept, match;

  assign cfg_pat_arr = cfg_pattern;
  assign cfg_ok      = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);

  // FSM: every cfg_load decides the state purely from the length's legality.
  always_comb begin
    state_d   = state_q;
    armed_d   = 1'b0;
    cfg_err_d = 1'b0;
    if (cfg_load) begin
      state_d = cfg_ok ? S_RUN : S_ERR;
    end
    armed_d   = (state_d == S_RUN);
    cfg_err_d = (state_d == S_ERR);
  end

  // Store the pattern pre-reversed for its length, so that pat_al[i] is the
  // symbol expected i positions before the newest one. This moves the
  // length-dependent indexing off the per-symbol path.
  always_comb begin
    pat_al_d = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      for (int j = 0; j < MAX_LEN; j++) begin
        if ((i + j + 1) == int'(cfg_len)) begin
          pat_al_d[i] = cfg_pat_arr[j];
        end
      end
    end
  end

  pattern_det_hist #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN)
  ) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .flush    (cfg_load),
    .d_in     (d_in),
    .pat      (pat_al_q),
    .eq       (eq)
  );

  // A load in the same cycle wins: its symbol is dropped.
  assign accept   = valid_in && (state_q == S_RUN) && !cfg_load;
  assign fill_inc = (fill_q == len_q) ? len_q : fill_q + LEN_W'(1);

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  // Positions beyond len_q are forced true so older history is ignored.
  assign match = accept && (fill_inc == len_q) && (&(eq | ~len_mask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_UNCFG;
      armed            <= 1'b0;
      cfg_err          <= 1'b0;
      len_q            <= '0;
      overlap_q        <= 1'b0;
      pat_al_q         <= '0;
      fill_q           <= '0;
      pattern_detected <= 1'b0;
      match_count      <= '0;
    end else begin
      state_q          <= state_d;
      armed            <= armed_d;
      cfg_err          <= cfg_err_d;
      pattern_detected <= match;

      if (cfg_load) begin
        len_q     <= cfg_len;
        overlap_q <= cfg_overlap;
        pat_al_q  <= pat_al_d;
      end

      if (cfg_load) begin
        fill_q <= '0;
      end else if (accept) begin
        fill_q <= (match && !overlap_q) ? '0 : fill_inc;
      end

      // Clear wins over an increment from a coincident match.
      if (count_clr) begin
        match_count <= '0;
      end else if (match && !(&match_count)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pattern_det_prog.md
# pattern_det_prog

Runtime-programmable serial pattern detector. It generalises the fixed five-symbol Bike/Car detector to patterns of up to MAX_LEN symbols of SYM_W bits each, loaded at run time, with selectable overlapping or non-overlapping matching. It also keeps a saturating match counter. It sits on the same symbol stream (d_in qualified by valid_in) as the existing detectors and feeds event and statistics logic downstream.

## Interface
- SYM_W, 1: bits per symbol (1 = Bike/Car).
- MAX_LEN, 8: maximum pattern length in symbols, at least 2.
- LEN_W, $clog2(MAX_LEN+1): width of cfg_len.
- CNT_W, 16: width of match_count.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- cfg_load  in  1: one-cycle pulse that captures cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN*SYM_W: pattern; symbol 0 (the first received) sits in bits [SYM_W-1:0].
- cfg_len  in  LEN_W: pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1: 1 = overlapping matches allowed; 0 = history restarts after each match.
- valid_in  in  1: d_in is sampled only when valid_in is high.
- d_in  in  SYM_W: input symbol.
- count_clr  in  1: synchronous clear of match_count.
- armed  out  1: a legal configuration is loaded and detection is running.
- cfg_err  out  1: the last cfg_load carried an illegal cfg_len.
- pattern_detected  out  1: one-cycle pulse per match.
- match_count  out  CNT_W: number of matches since the last clear; saturates at all-ones.

## Operation
- Control FSM has three states.
  - S_UNCFG: the reset state; nothing is detected.
  - S_RUN: armed is 1.
  - S_ERR: cfg_err is 1.
- Transitions:
  - Any state, cfg_load with cfg_len in 1..MAX_LEN: go to S_RUN.
  - Any state, cfg_load with cfg_len of 0 or above MAX_LEN: go to S_ERR.
  - No other transitions exist.
- Every cfg_load flushes the history: fill is set to 0 and the history contents are don't-care.
- The history register holds the last MAX_LEN accepted symbols. Newest is at index 0.
- fill counts accepted symbols and saturates at the configured length (len_q).
- On each valid_in in S_RUN:
  - the new symbol is shifted in;
  - fill_next = min(fill+1, len_q);
  - a match occurs when fill_next == len_q and, for every i < len_q, the symbol received i symbols before the new one equals pattern symbol len_q-1-i.
  - Comparison uses only len_q symbols; older history is ignored.
- On a match:
  - pattern_detected pulses;
  - match_count increments unless it is already all-ones;
  - if cfg_overlap_q is 0, fill is forced to 0 so the next match needs len_q fresh symbols;
  - if cfg_overlap_q is 1, fill stays at len_q.
- Cycles with valid_in low change nothing, and pattern_detected is 0 in those cycles.
- Priority when events coincide:
  - cfg_load beats valid_in: that cycle's symbol is discarded and no match is possible.
  - count_clr beats an increment: match_count becomes 0 even if a match occurs, but pattern_detected still pulses.
  - match_count is not cleared by cfg_load.
- Reset values (rst_n low, asynchronous): FSM in S_UNCFG; armed, cfg_err and pattern_detected are 0; match_count, fill, history and the config registers are 0.
- Reset asserted mid-pattern discards any partial match. After release, detection resumes only after a new cfg_load.

## Timing
- All outputs are registered.
- A match completed by the symbol sampled at edge N gives pattern_detected = 1 for exactly the cycle after edge N. match_count updates at the same edge N.
- armed and cfg_err update at the edge that samples cfg_load. The first symbol that can count is the one sampled at the next valid_in edge.
- Back-to-back valid_in is supported at one symbol per clock with no stall. No backpressure exists.
- len_q = 1 with overlap: every matching symbol produces a pulse, so pattern_detected can stay high on consecutive cycles.

## Structure
- pattern_det_pkg holds:
  - FSM state encoding (S_UNCFG = 2'b00, S_RUN = 2'b01, S_ERR = 2'b10);
  - symbol constants B = 1'b0, C = 1'b1 for SYM_W = 1 benches.
- One sub-module, pattern_det_hist: the parametrised shift register plus per-position equality vector. It takes SYM_W and MAX_LEN, and has a shift enable and a flush.
- The top level contains the FSM, the config registers, the len_q-masked compare reduction, fill, and the counter.

## Test plan
- Legacy pattern: load cfg_len=5, pattern B,B,C,B,C (cfg_pattern[4:0] = 5'b10100), cfg_overlap=0; stream 0,0,1,0,1 -> one pulse the cycle after the 5th symbol; match_count = 1.
- Overlap mode: load pattern 1,0,1 with len 3, then stream 1,0,1,0,1.
  - cfg_overlap=1 -> pulses after symbols 3 and 5; count = 2.
  - cfg_overlap=0 -> pulse after symbol 3 only; count = 1.
- Gaps and illegal length:
  - Valid gaps: insert idle cycles (valid_in=0, d_in toggling) between pattern symbols -> detection is unaffected.
  - Illegal length: cfg_len = 0 -> cfg_err = 1, armed = 0, and no pulses on any stream.
- Collisions:
  - cfg_load in the same cycle as a completing symbol -> no pulse; history flushed.
  - count_clr in the same cycle as a match -> pulse present; match_count = 0.
- Saturation and reset: with CNT_W=2, produce 5 matches -> count holds at 3. Assert rst_n low mid-pattern -> outputs clear immediately, armed = 0.
- Multi-bit symbols: SYM_W=2, MAX_LEN=4, pattern 3,0,2,1 -> detects only the exact sequence; a near miss such as 3,0,2,2 gives no pulse.
